spi_xact_arb: RTL
=================

# spi_xact_arb

Arbiter and sequencer that shares the single SPI master among three requesters: AFE gain setup, trigger-level setup, and calibration EEPROM reads. Each requester asks for one 16-bit transaction to a chosen slave select. The block grants requesters in round-robin order and launches the transaction on the SPI master. It holds the slave-select code stable for the whole transaction and the inter-frame gap, then returns the read data with a completion pulse. It sits between the digital core's requesters and the SPI master / slave-select decode (code 0 = trig, 1–3 = ch1–ch3, 4 = EEP; any other code = none selected).

## Interface
- GAP_CYC, 4: idle cycles after each completion before the next grant; must be ≥1.
- TMO_CYC, 1024: maximum cycles spent waiting for spi_done before abort; must be ≥16.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  3  per-requester level request; held until that requester's done pulse
- req0_cmd, req1_cmd, req2_cmd  in  16 each  SPI command word per requester
- req0_ss, req1_ss, req2_ss  in  3 each  slave-select code per requester
- done  out  3  one-cycle completion pulse, to the granted requester only
- err  out  1  valid with done; 1 = aborted (bad ss or timeout)
- rd_data  out  16  data from the last completion; held until the next completion
- busy  out  1  high in any state other than IDLE
- wrt_spi  out  1  one-cycle launch pulse to the SPI master
- spi_cmd  out  16  command to the SPI master; registered
- ss  out  3  slave-select code to the decode; registered
- spi_done  in  1  SPI master transaction-complete pulse
- spi_data  in  16  SPI master returned data; valid with spi_done

## Operation
- States: IDLE, LAUNCH, WAIT, GAP.
- IDLE:
  - If any req bit is high, grant the first asserted requester, searching from pointer ptr upward with wrap (ptr → ptr+1 → ptr+2, mod 3).
  - On grant, latch that requester's cmd into spi_cmd and its ss into ss, record the grant index g, and set ptr to (g+1) mod 3.
  - If the latched ss is 0–4, go to LAUNCH.
  - If the latched ss is 5–7: no SPI access, wrt_spi stays 0; next edge pulses done[g] with err=1 and rd_data=16'h0000, and the state goes to GAP.
- LAUNCH: wrt_spi=1 for exactly this cycle; go to WAIT; clear the timeout counter.
- WAIT:
  - On spi_done=1: next edge sets rd_data=spi_data, pulses done[g] with err=0, goes to GAP.
  - If the counter reaches TMO_CYC with no spi_done: pulse done[g] with err=1, leave rd_data unchanged, go to GAP.
- GAP: count GAP_CYC cycles, then go to IDLE. ss and spi_cmd hold their values throughout GAP.
- After GAP, ss returns to 3'b111. spi_cmd holds its last value.
- spi_done is ignored outside WAIT.
- A requester dropping req after grant does not cancel its transaction; done still pulses.
- A requester dropping req before grant is simply not serviced.
- A requester must drop req within GAP_CYC cycles after its done pulse, otherwise it is served again when its turn comes.

## Timing
- Reset values:
  - state IDLE, ptr=0 (requester 0 has first priority)
  - ss=3'b111, spi_cmd=0, wrt_spi=0, done=0, err=0, rd_data=0, busy=0
  - counters 0
- Reset mid-transaction:
  - outputs return to reset values immediately
  - no done pulse and no relaunch
  - a spi_done arriving after reset is ignored
- Grant latency: req sampled high at edge N (state IDLE) → ss/spi_cmd valid after N → wrt_spi high in cycle N+1.
- ss is valid at least one cycle before wrt_spi and stays stable until the end of GAP.
- Completion: spi_done high in cycle M → done[g]/err/rd_data valid in cycle M+1.
- done and err are high for exactly one cycle.
- Minimum spacing between wrt_spi pulses: 2 + SPI duration + 1 + GAP_CYC cycles.
- Timeout fires TMO_CYC cycles after LAUNCH.
- Simultaneous requests resolve by round-robin only; no requester is starved. With all three continuously asserted, grant order is 0,1,2,0,…

## Test plan
- Single request: req=3'b010, req1_cmd=16'hA5C3, req1_ss=3'b001 → wrt_spi one cycle after req, spi_cmd=16'hA5C3, ss=1; model spi_done with spi_data=16'h00FF → next cycle done=3'b010, err=0, rd_data=16'h00FF; ss=3'b111 after GAP_CYC.
- Round-robin: all req held high, distinct cmds → grants in order 0,1,2,0; wrt_spi pulses separated by at least GAP_CYC+3 cycles; ss never changes while busy is in LAUNCH/WAIT/GAP.
- Invalid select: req0_ss=3'b110 → no wrt_spi, done[0] with err=1, rd_data=0.
- Timeout: spi_done never asserted → done with err=1 exactly TMO_CYC cycles after LAUNCH; rd_data retains its prior value; the block accepts the next request afterwards.
- Reset in WAIT: rst_n low → all outputs at reset values asynchronously; a later spi_done produces no done pulse.
- Spurious spi_done while IDLE or GAP → no done pulse and no state change.

Source files
------------

// File: rtl/spi_xact_arb.sv
// Round-robin arbiter that shares one SPI master among three requesters.
// Holds slave select through transaction and inter-frame gap; returns data with a done pulse.
module spi_xact_arb #(
  parameter int GAP_CYC = 4,
  parameter int TMO_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [15:0] req0_cmd,
  input  logic [15:0] req1_cmd,
  input  logic [15:0] req2_cmd,
  input  logic [2:0]  req0_ss,
  input  logic [2:0]  req1_ss,
  input  logic [2:0]  req2_ss,
  output logic [2:0]  done,
  output logic        err,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic        wrt_spi,
  output logic [15:0] spi_cmd,
  output logic [2:0]  ss,
  input  logic        spi_done,
  input  logic [15:0] spi_data
);

  localparam int CW = $clog2(TMO_CYC + GAP_CYC + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    g_q, g_d;
  logic          bad_q, bad_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    ss_q, ss_d;
  logic [15:0]   cmd_q, cmd_d;
  logic [2:0]    done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   rd_q, rd_d;

  logic          gnt_vld;
  logic [1:0]    gnt_idx;
  logic [2:0]    cand;
  logic [15:0]   sel_cmd;
  logic [2:0]    sel_ss;

  // Scan offsets high to low so the lowest offset from ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    cand    = 3'd0;
    for (int i = 2; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + 3'(i);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (req[cand[1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[1:0];
      end
    end
  end

  always_comb begin
    case (gnt_idx)
      2'd0:    begin sel_cmd = req0_cmd; sel_ss = req0_ss; end
      2'd1:    begin sel_cmd = req1_cmd; sel_ss = req1_ss; end
      default: begin sel_cmd = req2_cmd; sel_ss = req2_ss; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    bad_d   = bad_q;
    cnt_d   = cnt_q;
    ss_d    = ss_q;
    cmd_d   = cmd_q;
    rd_d    = rd_q;
    done_d  = 3'b000;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          cmd_d   = sel_cmd;
          ss_d    = sel_ss;
          g_d     = gnt_idx;
          ptr_d   = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
          bad_d   = (sel_ss > 3'd4);
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (bad_q) begin
          done_d  = 3'b001 << g_q;
          err_d   = 1'b1;
          rd_d    = 16'h0000;
          cnt_d   = CW'(GAP_CYC - 1);
          state_d = GAP;
        end else begin
          // Loaded so the abort is visible exactly TMO_CYC cycles after the launch cycle.
          cnt_d   = CW'(TMO_CYC - 2);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (spi_done) begin
          done_d  = 3'b001 << g_q;
          rd_d    = spi_data;
          cnt_d   = CW'(GAP_CYC - 1);
          state_d = GAP;
        end else if (cnt_q == '0) begin
          done_d  = 3'b001 << g_q;
          err_d   = 1'b1;
          cnt_d   = CW'(GAP_CYC - 1);
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        if (cnt_q == '0) begin
          ss_d    = 3'b111;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      g_q     <= 2'd0;
      bad_q   <= 1'b0;
      cnt_q   <= '0;
      ss_q    <= 3'b111;
      cmd_q   <= 16'h0000;
      done_q  <= 3'b000;
      err_q   <= 1'b0;
      rd_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
      ss_q    <= ss_d;
      cmd_q   <= cmd_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  assign wrt_spi = (state_q == LAUNCH) && !bad_q;
  assign busy    = (state_q != IDLE);
  assign ss      = ss_q;
  assign spi_cmd = cmd_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rd_data = rd_q;

endmodule
